// File: rtl/gauss3x3_stream_if.sv
// Pixel stream bundle: column input from a line-buffer reader, filtered pixel output to a sink.
// No storage; pure wiring between producer, filter and consumer.
// Both directions use valid/ack; a transfer happens when valid and ack are high together.
interface gauss3x3_stream_if #(
    parameter int PIX_W = 8
);
    logic [1:0]       i_mode;
    logic             i_line_start;
    logic [PIX_W-1:0] i_pixel_1;
    logic [PIX_W-1:0] i_pixel_2;
    logic [PIX_W-1:0] i_pixel_3;
    logic             i_pixel_valid;
    logic             o_pixel_ack;
    logic             o_pixel_valid;
    logic             i_pixel_ack;
    logic [PIX_W-1:0] o_pixel;

    // Filter side: consumes columns, produces pixels.
    modport slave (
        input  i_mode, i_line_start, i_pixel_1, i_pixel_2, i_pixel_3, i_pixel_valid, i_pixel_ack,
        output o_pixel_ack, o_pixel_valid, o_pixel
    );

    // Environment side: produces columns, consumes pixels.
    modport master (
        output i_mode, i_line_start, i_pixel_1, i_pixel_2, i_pixel_3, i_pixel_valid, i_pixel_ack,
        input  o_pixel_ack, o_pixel_valid, o_pixel
    );
endinterface

// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 filter (Gaussian / bypass / optional sharpen via GAUSS3X3_SHARPEN_EN) over a sliding 3-column window.
// Latency: column accepted at edge k gives o_pixel_valid after edge k+2 (window, kernel, output register).
// Backpressure: one global enable stalls every stage while the output is held unacknowledged; upstream ack follows it.
module gauss3x3_stream #(
    parameter int PIX_W = 8
) (
    input logic                i_clk,
    input logic                i_rst,
    gauss3x3_stream_if.slave   px
);
    localparam int SW = PIX_W + 4;

    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } col_t;

    // S0: window; only the newest column's mode tag is ever consulted, so older tags are not kept
    col_t             w0_q, w1_q, w2_q;
    col_t             w0_d, w1_d, w2_d;
    logic [1:0]       tag_q, tag_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             s0_vld_q, s0_vld_d;

    // S1: kernel result and valid
    logic [PIX_W-1:0] s1_pix_q;
    logic             s1_vld_q;
    logic [PIX_W-1:0] kern_pix;

    // S2: output register
    logic [PIX_W-1:0] out_pix_q;
    logic             out_vld_q;

    logic             en;
    logic             accept;

    assign en     = !(out_vld_q && !px.i_pixel_ack);
    assign accept = px.i_pixel_valid && en;

    assign px.o_pixel_ack   = en;
    assign px.o_pixel_valid = out_vld_q;
    assign px.o_pixel       = out_pix_q;

    function automatic logic [SW-1:0] ext(input logic [PIX_W-1:0] p);
        return {4'b0000, p};
    endfunction

    // Window shift, line-start clearing and fill counter; a bubble only clears the S0 valid
    always_comb begin
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        s0_vld_d = s0_vld_q;
        if (en) begin
            s0_vld_d = 1'b0;
        end
        if (accept) begin
            w0_d  = '{top: px.i_pixel_1, mid: px.i_pixel_2, bot: px.i_pixel_3};
            tag_d = px.i_mode;
            if (px.i_line_start) begin
                w1_d     = '0;
                w2_d     = '0;
                cnt_d    = 2'd1;
                s0_vld_d = 1'b0;
            end else begin
                w1_d     = w0_q;
                w2_d     = w1_q;
                s0_vld_d = (cnt_q == 2'd2);
                cnt_d    = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
            end
        end
    end

    logic [SW-1:0] gsum;
    assign gsum = ext(w2_q.top)        + (ext(w1_q.top) << 1) + ext(w0_q.top)
                + (ext(w2_q.mid) << 1) + (ext(w1_q.mid) << 2) + (ext(w0_q.mid) << 1)
                + ext(w2_q.bot)        + (ext(w1_q.bot) << 1) + ext(w0_q.bot);

`ifdef GAUSS3X3_SHARPEN_EN
    function automatic logic signed [SW-1:0] sx(input logic [PIX_W-1:0] p);
        return signed'(ext(p));
    endfunction

    logic signed [SW-1:0] ssum;
    logic [PIX_W-1:0]     sharp_pix;
    assign ssum = (sx(w1_q.mid) <<< 2) + sx(w1_q.mid)
                - sx(w1_q.top) - sx(w1_q.bot) - sx(w0_q.mid) - sx(w2_q.mid);

    // Clamp the signed sum: negative goes to 0, anything above the pixel range saturates
    always_comb begin
        sharp_pix = ssum[PIX_W-1:0];
        if (ssum[SW-1]) begin
            sharp_pix = '0;
        end else if (|ssum[SW-2:PIX_W]) begin
            sharp_pix = '1;
        end
    end
`endif

    // Kernel select by the newest column's tag; unassigned modes fall back to Gaussian
    always_comb begin
        kern_pix = gsum[SW-1:4];
        case (tag_q)
            2'b01:   kern_pix = w1_q.mid;
`ifdef GAUSS3X3_SHARPEN_EN
            2'b10:   kern_pix = sharp_pix;
`endif
            default: kern_pix = gsum[SW-1:4];
        endcase
    end

    // State registers; every stage advances together under the global enable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w0_q      <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            s0_vld_q  <= 1'b0;
            s1_pix_q  <= '0;
            s1_vld_q  <= 1'b0;
            out_pix_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            s0_vld_q <= s0_vld_d;
            if (en) begin
                s1_pix_q  <= kern_pix;
                s1_vld_q  <= s0_vld_q;
                out_pix_q <= s1_pix_q;
                out_vld_q <= s1_vld_q;
            end
        end
    end
endmodule

// File: tb/tb_gauss3x3_stream.sv
// Directed bench for gauss3x3_stream: vector table of columns with expected outputs,
// plus hand sequences for output stall, and reset while a result is in flight.
module tb_gauss3x3_stream;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gauss3x3_stream_if #(.PIX_W(8)) bus ();

    gauss3x3_stream #(.PIX_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .px    (bus)
    );

`ifdef GAUSS3X3_SHARPEN_EN
    localparam int SH_A = 255;
    localparam int SH_B = 0;
`else
    localparam int SH_A = 63;
    localparam int SH_B = 216;
`endif

    typedef struct {
        logic       vld;
        logic       ls;
        logic [1:0] mode;
        logic [7:0] p1, p2, p3;
        logic       exp_vld;
        logic [7:0] exp_pix;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    function automatic vec_t mk(int v, int l, int m, int a, int b, int c, int ev, int ep);
        vec_t r;
        r.vld     = v[0];
        r.ls      = l[0];
        r.mode    = m[1:0];
        r.p1      = a[7:0];
        r.p2      = b[7:0];
        r.p3      = c[7:0];
        r.exp_vld = ev[0];
        r.exp_pix = ep[7:0];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_pixel_valid = 1'b0;
        bus.i_line_start  = 1'b0;
        bus.i_mode        = 2'd0;
        bus.i_pixel_1     = '0;
        bus.i_pixel_2     = '0;
        bus.i_pixel_3     = '0;
    endtask

    task automatic drive_col(input logic l, input logic [1:0] m, input logic [7:0] a, b, c);
        bus.i_pixel_valid = 1'b1;
        bus.i_line_start  = l;
        bus.i_mode        = m;
        bus.i_pixel_1     = a;
        bus.i_pixel_2     = b;
        bus.i_pixel_3     = c;
    endtask

    task automatic do_reset();
        drive_idle();
        bus.i_pixel_ack = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int        ci;
        int        stall_left;
        bit        stalled_once;
        bit        acc;
        bit        seen;
        int        held;
        int        got [$];
        int        sexp [4];
        logic [7:0] smid [6];
        int        pat [6];

        tbl[0]  = mk(1,1,0, 16, 16, 16, 0, 0);
        tbl[1]  = mk(1,0,0, 16, 16, 16, 0, 0);
        tbl[2]  = mk(1,0,0, 16, 16, 16, 1, 16);
        tbl[3]  = mk(0,0,0,  0,  0,  0, 0, 0);
        tbl[4]  = mk(1,1,0,  0,  0,  0, 0, 0);
        tbl[5]  = mk(1,0,0,  0,160,  0, 0, 0);
        tbl[6]  = mk(1,0,0,  0,  0,  0, 1, 40);
        tbl[7]  = mk(1,0,0,  0,  0,  0, 1, 20);
        tbl[8]  = mk(1,1,1,  1,  2,  3, 0, 0);
        tbl[9]  = mk(1,0,1,  4,  5,  6, 0, 0);
        tbl[10] = mk(1,0,1,  7,  8,  9, 1, 5);
        tbl[11] = mk(1,0,1, 10, 11, 12, 1, 8);
        tbl[12] = mk(1,0,0, 10, 20, 30, 1, 12);
        tbl[13] = mk(1,1,2,  0,  0,  0, 0, 0);
        tbl[14] = mk(1,0,2,  0,255,  0, 0, 0);
        tbl[15] = mk(1,0,2,  0,  0,  0, 1, SH_A);
        tbl[16] = mk(1,1,2,255,255,255, 0, 0);
        tbl[17] = mk(1,0,2,255,100,255, 0, 0);
        tbl[18] = mk(1,0,2,255,255,255, 1, SH_B);
        tbl[19] = mk(1,1,3,  0,  0,  0, 0, 0);
        tbl[20] = mk(1,0,3,  0,160,  0, 0, 0);
        tbl[21] = mk(1,0,3,  0,  0,  0, 1, 40);
        tbl[22] = mk(1,1,0, 48, 48, 48, 0, 0);
        tbl[23] = mk(1,0,0, 48, 48, 48, 0, 0);
        tbl[24] = mk(1,0,0, 48, 48, 48, 1, 48);
        tbl[25] = mk(1,1,0,  0,  0,  0, 0, 0);
        tbl[26] = mk(1,0,0,  0, 16,  0, 0, 0);
        tbl[27] = mk(1,0,0,  0,  0,  0, 1, 4);
        tbl[28] = mk(1,1,0,  0,  0,  0, 0, 0);
        tbl[29] = mk(1,0,0,  0, 16,  0, 0, 0);
        tbl[30] = mk(0,1,0,200,200,200, 0, 0);
        tbl[31] = mk(1,0,0,  0,  0,  0, 1, 4);

        // Reset state
        do_reset();
        chk("reset_o_pixel_valid", int'(bus.o_pixel_valid), 0);
        chk("reset_o_pixel",       int'(bus.o_pixel), 0);
        chk("reset_o_pixel_ack",   int'(bus.o_pixel_ack), 1);

        // Table: one row per cycle, each row's output checked two edges after its accept
        for (int t = 0; t < NV + 2; t++) begin
            if (t < NV) begin
                bus.i_pixel_valid = tbl[t].vld;
                bus.i_line_start  = tbl[t].ls;
                bus.i_mode        = tbl[t].mode;
                bus.i_pixel_1     = tbl[t].p1;
                bus.i_pixel_2     = tbl[t].p2;
                bus.i_pixel_3     = tbl[t].p3;
            end else begin
                drive_idle();
            end
            @(posedge clk);
            #1;
            if (t >= 2) begin
                chk($sformatf("vec%0d_valid", t - 2), int'(bus.o_pixel_valid), int'(tbl[t-2].exp_vld));
                if (tbl[t-2].exp_vld)
                    chk($sformatf("vec%0d_pixel", t - 2), int'(bus.o_pixel), int'(tbl[t-2].exp_pix));
            end
        end

        // Output stall: ack low 5 cycles once the first result is presented
        do_reset();
        smid = '{8'd0, 8'd160, 8'd0, 8'd0, 8'd80, 8'd0};
        sexp = '{40, 20, 10, 20};
        ci = 0;
        stall_left = 0;
        stalled_once = 1'b0;
        held = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (ci < 6) drive_col(ci == 0, 2'd0, 8'd0, smid[ci], 8'd0);
            else        drive_idle();
            if (!stalled_once && bus.o_pixel_valid) begin
                stalled_once = 1'b1;
                stall_left   = 5;
                held         = int'(bus.o_pixel);
            end
            bus.i_pixel_ack = (stall_left == 0);
            #2;
            if (stall_left > 0) begin
                chk("stall_pixel_stable", int'(bus.o_pixel), held);
                chk("stall_valid_held",   int'(bus.o_pixel_valid), 1);
                chk("stall_ack_low",      int'(bus.o_pixel_ack), 0);
                stall_left--;
            end
            acc = bus.i_pixel_valid && bus.o_pixel_ack;
            if (bus.o_pixel_valid && bus.i_pixel_ack) got.push_back(int'(bus.o_pixel));
            @(posedge clk);
            #1;
            if (acc) ci++;
        end
        bus.i_pixel_ack = 1'b1;
        chk("stall_happened",      int'(stalled_once), 1);
        chk("stall_columns_taken", ci, 6);
        chk("stall_output_count",  got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall_out%0d", i), (i < got.size()) ? got[i] : -1, sexp[i]);

        // Reset while a result is valid, then the line needs three fresh columns
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_col(i == 0, 2'd0, 8'd16, 8'd16, 8'd16);
            @(posedge clk);
            #1;
        end
        drive_idle();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.o_pixel_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rst_pre_valid_seen", int'(seen), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_valid", int'(bus.o_pixel_valid), 0);
        chk("rst_mid_pixel", int'(bus.o_pixel), 0);
        pat = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive_col(1'b0, 2'd0, 8'd16, 8'd16, 8'd16);
            else       drive_idle();
            @(posedge clk);
            #1;
            chk($sformatf("rst_after_valid%0d", i), int'(bus.o_pixel_valid), pat[i]);
            if (pat[i] == 1) chk("rst_after_pixel", int'(bus.o_pixel), 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
